// File: rtl/pwm_bank.sv
// Bank of PWM channels that share one counter. The counter runs edge-aligned or center-aligned.
// Level and period updates are double-buffered and take effect only at a period boundary.
module pwm_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_level,
    input  logic [CHANNELS-1:0] invert,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic [WIDTH-1:0]    cnt
);

    localparam logic DirUp   = 1'b0;
    localparam logic DirDown = 1'b1;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [WIDTH-1:0]    period_act_q;
    logic                mode_act_q;
    logic [WIDTH-1:0]    pend_q [CHANNELS];
    logic [WIDTH-1:0]    act_q  [CHANNELS];
    logic [WIDTH-1:0]    pend_d [CHANNELS];
    logic                start_q;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                ps_q;
    logic                bnd;
    logic                load;
    logic                wr_valid;

    assign wr_valid = wr_en && (32'(wr_ch) < CHANNELS);

    // Last cycle of the current period.
    always_comb begin
        if (!mode_act_q) begin
            bnd = (cnt_q == period_act_q);
        end else begin
            bnd = (period_act_q == '0) || (dir_q == DirDown && cnt_q == WIDTH'(1));
        end
    end

    assign load = !en || bnd;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load) begin
            cnt_d = '0;
            dir_d = DirUp;
        end else if (!mode_act_q || dir_q == DirUp) begin
            cnt_d = cnt_q + WIDTH'(1);
            // Turn around as the counter reaches the top, so the top value is seen exactly once.
            dir_d = (mode_act_q && cnt_d == period_act_q) ? DirDown : DirUp;
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // A write in a load cycle is merged into the value that gets loaded.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            pend_d[i] = (wr_valid && wr_ch == CH_W'(i)) ? wr_level : pend_q[i];
        end
    end

    always_comb begin
        pwm_d = invert;
        if (en) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pwm_d[i] = (cnt_q < act_q[i]) ^ invert[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dir_q        <= DirUp;
            period_act_q <= '0;
            mode_act_q   <= 1'b0;
            start_q      <= 1'b1;
            pwm_q        <= '0;
            ps_q         <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            start_q <= load;
            pwm_q   <= pwm_d;
            ps_q    <= en && start_q && (cnt_q == '0);
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pend_q[i] <= pend_d[i];
            end
            if (load) begin
                period_act_q <= period;
                mode_act_q   <= mode;
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    act_q[i] <= pend_d[i];
                end
            end
        end
    end

    assign cnt          = cnt_q;
    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Randomised and directed stimulus for pwm_bank. A period-position reference model feeds a
// scoreboard queue, and a monitor compares the DUT outputs against it.
module tb_pwm_bank;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n, en, mode, wr_en, period_start;
    logic [W-1:0]  period, wr_level, cnt;
    logic [CW-1:0] wr_ch;
    logic [N-1:0]  invert, pwm_out;

    always #5 clk = ~clk;

    pwm_bank #(.WIDTH(W), .CHANNELS(N), .CH_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_level(wr_level), .invert(invert),
        .pwm_out(pwm_out), .period_start(period_start), .cnt(cnt)
    );

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [N-1:0] pwm;
        logic         ps;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // The model tracks the position p within the current period and derives the counter from it.
    int m_p, m_per, m_mode;
    int m_pend[N];
    int m_act[N];

    function automatic int cnt_of(int p, int per, int md);
        return (md == 0 || p <= per) ? p : 2 * per - p;
    endfunction

    function automatic int len_of(int per, int md);
        if (md == 0) return per + 1;
        return (per == 0) ? 1 : 2 * per;
    endfunction

    task automatic step();
        exp_t e;
        int   newpend[N];
        int   c;
        newpend = m_pend;
        e = '0;
        if (!rst_n) begin
            m_p = 0; m_per = 0; m_mode = 0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_act[i]  = 0;
            end
        end else begin
            if (wr_en && int'(wr_ch) < N) newpend[int'(wr_ch)] = int'(wr_level);
            if (!en) begin
                e.pwm  = invert;
                m_act  = newpend;
                m_per  = int'(period);
                m_mode = int'(mode);
                m_p    = 0;
            end else begin
                c = cnt_of(m_p, m_per, m_mode);
                for (int i = 0; i < N; i++) e.pwm[i] = (c < m_act[i]) ^ invert[i];
                e.ps = (m_p == 0);
                if (m_p == len_of(m_per, m_mode) - 1) begin
                    m_act  = newpend;
                    m_per  = int'(period);
                    m_mode = int'(mode);
                    m_p    = 0;
                end else begin
                    m_p++;
                end
                e.cnt = W'(cnt_of(m_p, m_per, m_mode));
            end
            m_pend = newpend;
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic write_lvl(input int ch, input int lvl);
        wr_en = 1'b1; wr_ch = CW'(ch); wr_level = W'(lvl);
        step();
        wr_en = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({cnt, pwm_out, period_start} !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got cnt=%0d pwm=%b ps=%b, required cnt=%0d pwm=%b ps=%b",
                             vectors, $time, cnt, pwm_out, period_start, e.cnt, e.pwm, e.ps);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; period = '0;
        wr_en = 1'b0; wr_ch = '0; wr_level = '0; invert = '0;
        m_p = 0; m_per = 0; m_mode = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
        @(negedge clk);
        step(); step();

        // Idle output follows invert.
        rst_n = 1'b1; invert = 4'b0101;
        repeat (3) step();
        invert = '0;

        // Edge mode, levels 0/5/10/255.
        write_lvl(0, 0); write_lvl(1, 5); write_lvl(2, 10); write_lvl(3, 255);
        period = 9; mode = 1'b0; step();
        en = 1'b1;
        repeat (30) step();

        // Center mode, period 4, level 2.
        en = 1'b0; write_lvl(0, 2); period = 4; mode = 1'b1; step();
        en = 1'b1;
        repeat (24) step();

        // Full-range edge period.
        en = 1'b0; write_lvl(0, 127); period = 255; mode = 1'b0; step();
        en = 1'b1;
        repeat (520) step();

        // Mid-period write stays pending, and a write on the boundary cycle applies next period.
        en = 1'b0; write_lvl(0, 50); step();
        en = 1'b1;
        repeat (50) step();
        write_lvl(0, 200);
        repeat (300) step();
        while (m_p != 255) step();
        write_lvl(0, 30);
        repeat (260) step();

        // An out-of-range channel write must not touch any channel.
        write_lvl(5, 77); write_lvl(7, 1);
        repeat (20) step();

        // Reset in the middle of a run.
        invert = 4'b1010;
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        repeat (10) step();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(199) != 0);
            if ($urandom_range(99) == 0) en = ~en;
            if ($urandom_range(39) == 0) begin
                mode   = 1'($urandom_range(1));
                period = ($urandom_range(9) == 0) ? 8'd255 : W'($urandom_range(12));
            end
            wr_en    = ($urandom_range(3) == 0);
            wr_ch    = CW'($urandom_range(7));
            wr_level = ($urandom_range(7) == 0) ? W'($urandom_range(255)) : W'($urandom_range(15));
            if ($urandom_range(49) == 0) invert = N'($urandom_range(15));
            step();
        end
        wr_en = 1'b0;

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/level/period bit width (2..16).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent PWM outputs (1..16).
REQ-003 SHALL have parameter CH_W, default 2, channel-select width; CH_W >= max(1, clog2(CHANNELS)).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 en  input  1  1 = run counter; 0 = idle.
REQ-007 mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary.
REQ-008 period  input  WIDTH  counter top value; sampled at period boundary.
REQ-009 wr_en  input  1  write strobe for one channel's pending level.
REQ-010 wr_ch  input  CH_W  target channel; writes with wr_ch >= CHANNELS ignored.
REQ-011 wr_level  input  WIDTH  duty level to write.
REQ-012 invert  input  CHANNELS  per-channel output polarity, applied combinationally before output register.
REQ-013 pwm_out  output  CHANNELS  registered PWM outputs.
REQ-014 period_start  output  1  registered one-cycle pulse marking first cycle of each period.
REQ-015 cnt  output  WIDTH  current counter value.

Function
REQ-016 Each channel SHALL hold a pending level (written by wr_en) and an active level (used for compare).
REQ-017 Boundary B SHALL be true in the last cycle of a period: edge mode cnt == period_act; center mode direction down and cnt == 1, or period_act == 0.
REQ-018 On B (or every cycle while en=0): active <- pending for all channels, period_act <- period, mode_act <- mode; a wr_en in the same cycle SHALL be included in that load.
REQ-019 Edge mode: cnt counts 0,1,..,period_act, then 0; period length period_act+1 cycles.
REQ-020 Center mode: cnt counts 0 up to period_act, then down to 1, then 0; period length 2*period_act cycles; period_act=0 gives cnt held at 0, length 1.
REQ-021 Raw output per channel SHALL be (cnt < active_level); level 0 -> constantly low, level > period_act -> constantly high.
REQ-022 Center mode high time for level L in 1..period_act SHALL be 2L-1 cycles, symmetric about cnt==period_act.
REQ-023 pwm_out[i] SHALL register raw[i] XOR invert[i]; latency exactly one cycle from cnt.
REQ-024 period_start SHALL be registered (cnt == 0 && en && starting a period), i.e. high the cycle after cnt entered 0.
REQ-025 en=0: cnt forced to 0, direction up, pwm_out = invert, period_start = 0.
REQ-026 en rising: period starts at cnt=0 on the first en=1 cycle with config loaded during idle.
REQ-027 Mid-period writes SHALL NOT change pwm_out until the next period (glitch-free).
REQ-028 Arithmetic SHALL be unsigned WIDTH-bit; no counter overflow for period = 2^WIDTH-1.

Reset
REQ-029 rst_n=0 at clock edge: cnt=0, direction up, all pending/active=0, period_act=0, mode_act=0, pwm_out=0, period_start=0.
REQ-030 Reset mid-period SHALL abort the period immediately; first cycle after release is idle or period start per en.

Verification
REQ-031 WIDTH=8, edge, period=255, ch0 level=127, en=1 -> ch0 high 127 of every 256 cycles, period_start every 256 cycles.
REQ-032 Edge, period=9, levels {0,5,10,255}, invert=0 -> ch0 always low, ch1 high 5/10, ch2 and ch3 always high.
REQ-033 Center, period=4, level=2 -> cnt 0,1,2,3,4,3,2,1 repeating; pwm_out high 3 of 8 cycles, centered.
REQ-034 Write level 200 at cnt=50 of period=255 with old level 50 -> duty stays 50 until cnt wraps, then 200; write on B cycle applies next period.
REQ-035 invert=4'b0101 with en=0 -> pwm_out=4'b0101; rst_n=0 mid-run -> pwm_out=0, cnt=0 next cycle.
REQ-036 Write with wr_ch=5 when CHANNELS=4 (CH_W=3) -> no channel level changes.
